branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Dynamic branch predictor for the 5-stage pipelined core.
- Sits between IF (prediction lookup) and EX (branch resolution).
- Generates the flush, stall-qualified branch-type and statistics signals that the top-level performance monitor counts.
- Holds a direct-mapped table of 2-bit saturating counters indexed by instruction word address.

Parameters:
IDX_W, 4, table index width; table depth = 2**IDX_W entries
CNT_W, 16, width of the statistics counters
INIT_CTR, 2'b01, reset value of every table entry (weakly not-taken)

Ports:
clk  input  1  clock, rising-edge active
rst  input  1  asynchronous, active-low reset
stall  input  1  pipeline memory stall; freezes all state updates
if_pc  input  30  word address of the instruction in IF
pred_taken  output  1  prediction for if_pc; combinational
ex_valid  input  1  EX-stage instruction valid
ex_is_branch  input  1  EX instruction is a conditional branch
ex_pc  input  30  word address of the EX instruction
ex_taken  input  1  actual branch outcome from the EX comparator
ex_pred_taken  input  1  prediction carried down the pipeline with the instruction
flush  output  1  misprediction; kill IF/ID and redirect PC; combinational
br_type  output  1  a branch resolves this cycle; combinational
branch_cnt  output  CNT_W  number of resolved branches, registered
miss_cnt  output  CNT_W  number of mispredictions, registered

Behaviour:
- Reset (rst low, asynchronous):
  - All table entries = INIT_CTR.
  - branch_cnt = 0; miss_cnt = 0.
  - pred_taken reflects the reset table, i.e. 0.
  - flush and br_type depend only on their inputs.
  - Reset mid-operation discards all training immediately.
- Lookup:
  - pred_taken = table[if_pc[IDX_W-1:0]][1].
  - Zero latency; independent of stall.
- Resolve condition: res = ex_valid & ex_is_branch & ~stall.
  - br_type = res.
  - flush = res & (ex_taken != ex_pred_taken).
  - While stall is high, no flush or br_type is produced, so each branch is counted exactly once, in its final non-stalled EX cycle.
- Training on res, rising edge, entry uidx = ex_pc[IDX_W-1:0]:
  - ex_taken = 1: entry = min(entry+1, 3).
  - ex_taken = 0: entry = max(entry-1, 0).
  - Saturates at 2'b11 and 2'b00; no wrap.
  - The counter FSM is 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Predict taken when in states 10 or 11.
- Same-cycle lookup and update of the same index: pred_taken shows the old (pre-update) value. The new value is visible from the next cycle.
- Aliasing: different PCs with equal low IDX_W bits share one entry. No tags.
- Statistics:
  - branch_cnt increments by 1 on res.
  - miss_cnt increments by 1 on flush.
  - Both saturate at all-ones; no wrap.
- Non-branch or invalid EX instruction: no table, counter or output effect.
- ex_pred_taken is trusted as given. The unit does not re-read the table to decide flush.
- Redirect-target computation is out of scope; it is done in EX.

Test Plan:
- Reset, then if_pc = 30'h5 → pred_taken = 0, branch_cnt = 0, miss_cnt = 0, flush = 0.
- Resolve ex_pc = 30'h5, taken, ex_pred_taken = 0, once → flush = 1 and br_type = 1 that cycle; entry 5 = 10; next cycle pred_taken(if_pc = 5) = 1; branch_cnt = 1, miss_cnt = 1.
- Four taken resolves on pc 5, then one not-taken → entry walks 01→10→11→11→11→10; pred_taken stays 1 after the first resolve.
- Resolve with stall = 1 for 3 cycles, then stall = 0 for 1 cycle → flush/br_type are 0 during the stall and high for one cycle only; branch_cnt increments by exactly 1.
- Aliasing: train pc 30'h13 taken twice (IDX_W = 4) → pred_taken for if_pc = 30'h3 = 1.
- Same-cycle read/write on index 7, weak-NT, taken → pred_taken = 0 in that cycle, 1 in the next.
- Force 65535 mispredicts, then one more → miss_cnt holds 16'hFFFF.
- Assert rst mid-run after training → table back to 01 and counters to 0 without a clock edge.

Source files
------------

// File: rtl/branch_predict_unit_if.sv
// Branch predictor bus: IF lookup, EX resolution and statistics outputs.
// The pipeline side is the master; the predictor is the slave.
interface branch_predict_unit_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic [29:0]      if_pc;
    logic             pred_taken;
    logic             ex_valid;
    logic             ex_is_branch;
    logic [29:0]      ex_pc;
    logic             ex_taken;
    logic             ex_pred_taken;
    logic             flush;
    logic             br_type;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] miss_cnt;

    modport master (
        output stall, if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_pred_taken,
        input  pred_taken, flush, br_type, branch_cnt, miss_cnt
    );

    modport slave (
        input  stall, if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_pred_taken,
        output pred_taken, flush, br_type, branch_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor: direct-mapped table of 2-bit saturating counters
// indexed by the low word-address bits, with resolve/flush signalling and
// saturating branch / misprediction statistics.
module branch_predict_unit #(
    parameter int         IDX_W    = 4,
    parameter int         CNT_W    = 16,
    parameter logic [1:0] INIT_CTR = 2'b01
) (
    input logic                   clk,
    input logic                   rst,
    branch_predict_unit_if.slave  bp
);
    localparam int DEPTH = 1 << IDX_W;

    // Counter states; the upper bit is the taken prediction.
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // Next state of one 2-bit counter: step toward the outcome, hold at the ends.
    function automatic ctr_e ctr_train(input ctr_e cur, input logic taken);
        ctr_e nxt;
        nxt = cur;
        case (cur)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    ctr_e             table_q [DEPTH];
    ctr_e             table_d [DEPTH];
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q,   miss_cnt_d;

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             res;
    logic             mispredict;
    logic             unused_pc_hi;

    assign if_idx = bp.if_pc[IDX_W-1:0];
    assign ex_idx = bp.ex_pc[IDX_W-1:0];

    // Only the low index bits address the table; upper PC bits alias freely.
    assign unused_pc_hi = ^{bp.if_pc[29:IDX_W], bp.ex_pc[29:IDX_W]};

    // Resolve qualification and combinational outputs; a stalled EX stage
    // holds its branch back so it is counted once, in its last EX cycle.
    always_comb begin
        res            = bp.ex_valid & bp.ex_is_branch & ~bp.stall;
        mispredict     = res & (bp.ex_taken != bp.ex_pred_taken);
        bp.br_type     = res;
        bp.flush       = mispredict;
        bp.pred_taken  = table_q[if_idx][1];
        bp.branch_cnt  = branch_cnt_q;
        bp.miss_cnt    = miss_cnt_q;
    end

    // Training and statistics next-state; lookup sees the old entry this cycle.
    always_comb begin
        table_d      = table_q;
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (res) begin
            table_d[ex_idx] = ctr_train(table_q[ex_idx], bp.ex_taken);
            branch_cnt_d    = cnt_sat_inc(branch_cnt_q);
            if (mispredict) begin
                miss_cnt_d = cnt_sat_inc(miss_cnt_q);
            end
        end
    end

    // State registers; reset discards all training immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= ctr_e'(INIT_CTR);
            end
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            table_q      <= table_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed vector table, reset and saturation
// sequences, then random traffic against a behavioural model.
module tb_branch_predict_unit;
    logic clk;
    logic rst;

    branch_predict_unit_if #(.CNT_W(16)) bp_if ();

    branch_predict_unit #(
        .IDX_W(4),
        .CNT_W(16),
        .INIT_CTR(2'b01)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bp (bp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Behavioural model: counter values as plain integers 0..3.
    int m_ctr [16];
    int m_bc;
    int m_mc;

    typedef struct {
        logic        stall;
        logic [29:0] if_pc;
        logic        v;
        logic        br;
        logic [29:0] ex_pc;
        logic        tk;
        logic        pt;
        logic        e_pred;
        logic        e_flush;
        logic        e_br;
        int          e_bc;
        int          e_mc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic [29:0] ipc, input logic v, input logic br,
                       input logic [29:0] epc, input logic tk, input logic pt,
                       input logic ep, input logic ef, input logic eb, input int bc, input int mc);
        vec_t r;
        r.stall = st; r.if_pc = ipc; r.v = v; r.br = br; r.ex_pc = epc; r.tk = tk; r.pt = pt;
        r.e_pred = ep; r.e_flush = ef; r.e_br = eb; r.e_bc = bc; r.e_mc = mc;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_ctr[i] = 1;
        m_bc = 0;
        m_mc = 0;
    endtask

    // Apply the architectural effect of one clock edge with the given inputs.
    task automatic model_edge(input logic st, input logic v, input logic br,
                              input logic [29:0] epc, input logic tk, input logic pt);
        int idx;
        if (v && br && !st) begin
            idx = int'(epc % 16);
            if (tk) m_ctr[idx] = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
            else    m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
            if (m_bc < 65535) m_bc++;
            if (tk != pt && m_mc < 65535) m_mc++;
        end
    endtask

    task automatic drive(input logic st, input logic [29:0] ipc, input logic v, input logic br,
                         input logic [29:0] epc, input logic tk, input logic pt);
        bp_if.stall         = st;
        bp_if.if_pc         = ipc;
        bp_if.ex_valid      = v;
        bp_if.ex_is_branch  = br;
        bp_if.ex_pc         = epc;
        bp_if.ex_taken      = tk;
        bp_if.ex_pred_taken = pt;
    endtask

    // One cycle checked (optionally) against the model; starts and ends at negedge.
    task automatic cycle(input logic st, input logic [29:0] ipc, input logic v, input logic br,
                         input logic [29:0] epc, input logic tk, input logic pt, input bit do_chk);
        logic e_br;
        drive(st, ipc, v, br, epc, tk, pt);
        #1;
        e_br = v & br & ~st;
        if (do_chk) begin
            chk("rnd_pred",   32'(bp_if.pred_taken), 32'(m_ctr[int'(ipc % 16)] >= 2));
            chk("rnd_br",     32'(bp_if.br_type),    32'(e_br));
            chk("rnd_flush",  32'(bp_if.flush),      32'(e_br & (tk != pt)));
            chk("rnd_bcnt",   32'(bp_if.branch_cnt), 32'(m_bc));
            chk("rnd_mcnt",   32'(bp_if.miss_cnt),   32'(m_mc));
        end
        @(posedge clk);
        model_edge(st, v, br, epc, tk, pt);
        @(negedge clk);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        model_reset();
        rst = 1'b0;
        drive(1'b0, 30'h5, 1'b0, 1'b0, 30'h0, 1'b0, 1'b0);

        // Directed table; expected registered counts are those before each edge.
        //   st  if_pc  v  br ex_pc  tk pt  pred flush br  bc mc
        add(0, 30'h05, 0, 0, 30'h00, 0, 0,  0,   0,   0,  0, 0);
        add(0, 30'h05, 1, 1, 30'h05, 1, 0,  0,   1,   1,  0, 0);
        add(0, 30'h05, 0, 0, 30'h00, 0, 0,  1,   0,   0,  1, 1);
        add(0, 30'h05, 1, 1, 30'h05, 1, 1,  1,   0,   1,  1, 1);
        add(0, 30'h05, 1, 1, 30'h05, 1, 1,  1,   0,   1,  2, 1);
        add(0, 30'h05, 1, 1, 30'h05, 1, 1,  1,   0,   1,  3, 1);
        add(0, 30'h05, 1, 1, 30'h05, 0, 1,  1,   1,   1,  4, 1);
        add(0, 30'h05, 0, 0, 30'h00, 0, 0,  1,   0,   0,  5, 2);
        add(0, 30'h03, 1, 1, 30'h13, 1, 0,  0,   1,   1,  5, 2);
        add(0, 30'h03, 1, 1, 30'h13, 1, 1,  1,   0,   1,  6, 3);
        add(0, 30'h03, 0, 0, 30'h00, 0, 0,  1,   0,   0,  7, 3);
        add(0, 30'h07, 1, 1, 30'h07, 1, 0,  0,   1,   1,  7, 3);
        add(0, 30'h07, 0, 0, 30'h00, 0, 0,  1,   0,   0,  8, 4);
        add(0, 30'h07, 1, 0, 30'h07, 0, 1,  1,   0,   0,  8, 4);
        add(0, 30'h07, 0, 1, 30'h07, 0, 1,  1,   0,   0,  8, 4);
        add(0, 30'h07, 0, 0, 30'h00, 0, 0,  1,   0,   0,  8, 4);
        add(1, 30'h07, 1, 1, 30'h07, 0, 1,  1,   0,   0,  8, 4);
        add(1, 30'h07, 1, 1, 30'h07, 0, 1,  1,   0,   0,  8, 4);
        add(1, 30'h07, 1, 1, 30'h07, 0, 1,  1,   0,   0,  8, 4);
        add(0, 30'h07, 1, 1, 30'h07, 0, 1,  1,   1,   1,  8, 4);
        add(0, 30'h07, 0, 0, 30'h00, 0, 0,  0,   0,   0,  9, 5);
        add(0, 30'h05, 0, 0, 30'h00, 0, 0,  1,   0,   0,  9, 5);

        // Reset state, checked while reset is still held.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pred",  32'(bp_if.pred_taken), 32'd0);
        chk("rst_bcnt",  32'(bp_if.branch_cnt), 32'd0);
        chk("rst_mcnt",  32'(bp_if.miss_cnt),   32'd0);
        chk("rst_flush", 32'(bp_if.flush),      32'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].if_pc, vecs[i].v, vecs[i].br,
                  vecs[i].ex_pc, vecs[i].tk, vecs[i].pt);
            #1;
            chk($sformatf("vec%0d_pred", i),  32'(bp_if.pred_taken), 32'(vecs[i].e_pred));
            chk($sformatf("vec%0d_flush", i), 32'(bp_if.flush),      32'(vecs[i].e_flush));
            chk($sformatf("vec%0d_br", i),    32'(bp_if.br_type),    32'(vecs[i].e_br));
            chk($sformatf("vec%0d_bcnt", i),  32'(bp_if.branch_cnt), 32'(vecs[i].e_bc));
            chk($sformatf("vec%0d_mcnt", i),  32'(bp_if.miss_cnt),   32'(vecs[i].e_mc));
            @(posedge clk);
            model_edge(vecs[i].stall, vecs[i].v, vecs[i].br, vecs[i].ex_pc, vecs[i].tk, vecs[i].pt);
            @(negedge clk);
        end

        // Asynchronous reset mid-cycle after training: no clock edge needed.
        drive(1'b0, 30'h5, 1'b1, 1'b1, 30'h5, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_pred5", 32'(bp_if.pred_taken), 32'd0);
        chk("arst_bcnt",  32'(bp_if.branch_cnt), 32'd0);
        chk("arst_mcnt",  32'(bp_if.miss_cnt),   32'd0);
        chk("arst_flush", 32'(bp_if.flush),      32'd1);
        chk("arst_br",    32'(bp_if.br_type),    32'd1);
        bp_if.if_pc = 30'h3;
        #1;
        chk("arst_pred3", 32'(bp_if.pred_taken), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        // Entry must be exactly weak-NT: one taken resolve flips the prediction.
        cycle(1'b0, 30'h3, 1'b1, 1'b1, 30'h3, 1'b1, 1'b0, 1'b1);
        #1;
        chk("arst_retrain", 32'(bp_if.pred_taken), 32'd1);

        // Miss counter saturation.
        for (int i = 0; i < 65534; i++) begin
            logic t;
            t = 1'($urandom_range(0, 1));
            cycle(1'b0, 30'h0, 1'b1, 1'b1, 30'(i), t, ~t, 1'b0);
        end
        #1;
        chk("miss_at_max",   32'(bp_if.miss_cnt),   32'hFFFF);
        chk("branch_at_max", 32'(bp_if.branch_cnt), 32'hFFFF);
        cycle(1'b0, 30'h0, 1'b1, 1'b1, 30'h9, 1'b1, 1'b0, 1'b1);
        #1;
        chk("miss_sat",   32'(bp_if.miss_cnt),   32'hFFFF);
        chk("branch_sat", 32'(bp_if.branch_cnt), 32'hFFFF);

        // Fresh start, then random traffic against the model.
        rst = 1'b0;
        #1;
        chk("rst2_mcnt", 32'(bp_if.miss_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 2000; i++) begin
            cycle(1'($urandom_range(0, 3) == 0),
                  30'($urandom_range(0, 40)),
                  1'($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 3) != 0),
                  30'($urandom_range(0, 40)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
